// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - synchronised whole-vector switch debouncer with change strobe and previous value
module sw_debounce #(
  parameter int               WIDTH         = 4,
  parameter int               STABLE_CYCLES = 1_000_000,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_prev,
  output logic             sw_chg
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             chg_q, chg_d;

  // Two-flop synchroniser for the asynchronous switch pins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= sw_in;
      s2_q <= s1_q;
    end
  end

  // State, candidate, window counter and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cand_q  <= RESET_VAL;
      cnt_q   <= '0;
      out_q   <= RESET_VAL;
      prev_q  <= RESET_VAL;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      prev_q  <= prev_d;
      chg_q   <= chg_d;
    end
  end

  // Next state: any difference between s2 and the candidate restarts the stability window
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    prev_d  = prev_q;
    chg_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q != cand_q) begin
          cand_d  = s2_q;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          // A glitch that settled back to the current output is accepted silently
          if (cand_q != out_q) begin
            out_d  = cand_q;
            prev_d = out_q;
            chg_d  = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sw_out  = out_q;
  assign sw_prev = prev_q;
  assign sw_chg  = chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed vector bench for sw_debounce with STABLE_CYCLES = 4
module tb_sw_debounce;

  typedef struct {
    logic       rstn;
    logic [3:0] sw;
    logic [3:0] out;
    logic [3:0] prev;
    logic       chg;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] sw_in  = 4'h3;
  logic [3:0] sw_out;
  logic [3:0] sw_prev;
  logic       sw_chg;

  sw_debounce #(
    .WIDTH        (4),
    .STABLE_CYCLES(4),
    .RESET_VAL    (4'hf)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .sw_prev(sw_prev),
    .sw_chg (sw_chg)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] sw, input logic [3:0] o,
                     input logic [3:0] p, input logic c);
    vec_t v;
    v.rstn = r;
    v.sw   = sw;
    v.out  = o;
    v.prev = p;
    v.chg  = c;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] seq_vals[5];
    logic [3:0] old_out;
    logic [3:0] old_prev;
    int         pulses;

    // Reset held with switches at 3, then released with all switches off
    for (int j = 0; j < 3; j++)  add(1'b0, 4'h3, 4'hf, 4'hf, 1'b0);
    for (int j = 0; j < 20; j++) add(1'b1, 4'hf, 4'hf, 4'hf, 1'b0);
    // Clean change f -> 8: new output on the 7th sampled edge (E6)
    for (int j = 0; j < 9; j++) begin
      if (j < 6)       add(1'b1, 4'h8, 4'hf, 4'hf, 1'b0);
      else if (j == 6) add(1'b1, 4'h8, 4'h8, 4'hf, 1'b1);
      else             add(1'b1, 4'h8, 4'h8, 4'hf, 1'b0);
    end
    // Back to f
    for (int j = 0; j < 9; j++) begin
      if (j < 6)       add(1'b1, 4'hf, 4'h8, 4'hf, 1'b0);
      else if (j == 6) add(1'b1, 4'hf, 4'hf, 4'h8, 1'b1);
      else             add(1'b1, 4'hf, 4'hf, 4'h8, 1'b0);
    end
    // Three-cycle glitch to 8 is rejected
    for (int j = 0; j < 3; j++)  add(1'b1, 4'h8, 4'hf, 4'h8, 1'b0);
    for (int j = 0; j < 10; j++) add(1'b1, 4'hf, 4'hf, 4'h8, 1'b0);
    // Sequence 8, 9, e, 2, 0 each held 10 cycles
    seq_vals = '{4'h8, 4'h9, 4'he, 4'h2, 4'h0};
    old_out  = 4'hf;
    old_prev = 4'h8;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 10; j++) begin
        if (j < 6)       add(1'b1, seq_vals[k], old_out, old_prev, 1'b0);
        else if (j == 6) add(1'b1, seq_vals[k], seq_vals[k], old_out, 1'b1);
        else             add(1'b1, seq_vals[k], seq_vals[k], old_out, 1'b0);
      end
      old_prev = old_out;
      old_out  = seq_vals[k];
    end

    for (int i = 0; i < vecs.size(); i++) begin
      resetn = vecs[i].rstn;
      sw_in  = vecs[i].sw;
      step();
      check($sformatf("vec%0d.out", i),  32'(sw_out),  32'(vecs[i].out));
      check($sformatf("vec%0d.prev", i), 32'(sw_prev), 32'(vecs[i].prev));
      check($sformatf("vec%0d.chg", i),  32'(sw_chg),  32'(vecs[i].chg));
    end

    // Asynchronous reset clears outputs without waiting for a clock edge
    check("pre_async.out", 32'(sw_out), 32'h0);
    resetn = 1'b0;
    sw_in  = 4'hf;
    #1;
    check("async.out",  32'(sw_out),  32'hf);
    check("async.prev", 32'(sw_prev), 32'hf);
    check("async.chg",  32'(sw_chg),  32'h0);
    step();
    step();
    resetn = 1'b1;
    for (int j = 0; j < 3; j++) step();

    // Bounce 8/f for six cycles, then hold 8: exactly one pulse, six edges after the last transition
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      sw_in = (k % 2 == 0) ? 4'h8 : 4'hf;
      step();
      if (sw_chg) pulses++;
    end
    sw_in = 4'h8;
    for (int j = 0; j < 20; j++) begin
      step();
      if (sw_chg) pulses++;
      if (j == 5) check("bounce.out_e5", 32'(sw_out), 32'hf);
      if (j == 6) begin
        check("bounce.out_e6", 32'(sw_out), 32'h8);
        check("bounce.chg_e6", 32'(sw_chg), 32'h1);
      end
    end
    check("bounce.pulses", 32'(pulses), 32'd1);
    check("bounce.prev",   32'(sw_prev), 32'hf);

    // Return to f via reset, then reset two cycles into COUNT
    resetn = 1'b0;
    sw_in  = 4'hf;
    step();
    step();
    resetn = 1'b1;
    for (int j = 0; j < 3; j++) step();
    pulses = 0;
    sw_in  = 4'h8;
    for (int j = 0; j < 4; j++) begin
      step();
      if (sw_chg) pulses++;
    end
    resetn = 1'b0;
    sw_in  = 4'hf;
    #1;
    check("midcnt.out_rst", 32'(sw_out), 32'hf);
    check("midcnt.chg_rst", 32'(sw_chg), 32'h0);
    step();
    step();
    resetn = 1'b1;
    for (int j = 0; j < 15; j++) begin
      step();
      if (sw_chg) pulses++;
    end
    check("midcnt.pulses", 32'(pulses),  32'd0);
    check("midcnt.out",    32'(sw_out),  32'hf);
    check("midcnt.prev",   32'(sw_prev), 32'hf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
